// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core: one shared ALU and a single request/ready memory port.
// Any unsupported opcode, unsupported branch type or misaligned word access parks the core in HALT.
module riscv_multicycle #(
    parameter int unsigned MEM_AW   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned OUT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [OUT_W-1:0]  cpu_out,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_MEMWB  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9,
        S_LUI    = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: y = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            default:  y = a + b;
        endcase
        return y;
    endfunction

    // Bit 30 of the instruction only means sub for register-register adds; it always means sra for shifts.
    function automatic logic [3:0] alu_sel_f(input logic [2:0] f3, input logic alt, input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d, oldpc_q, oldpc_d, ir_q, ir_d;
    logic [31:0]        a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0]        aluout_q, aluout_d, mdr_q, mdr_d;
    logic [31:0]        rf_q [32];
    logic [31:0]        rf_d [32];
    logic [OUT_W-1:0]   cpu_out_q, cpu_out_d;
    logic               halted_q, halted_d;

    logic [6:0]         opcode_s;
    logic [4:0]         rd_s, rs1_s, rs2_s;
    logic [2:0]         funct3_s;
    logic [31:0]        imm_s, alu_a_s, alu_b_s, alu_y_s, rf_wdata_s;
    logic [3:0]         alu_op_s;
    logic               rf_we_s, take_s, mem_req_s, mem_we_s;
    logic [MEM_AW-1:0]  mem_addr_s;

    assign opcode_s = ir_q[6:0];
    assign rd_s     = ir_q[11:7];
    assign funct3_s = ir_q[14:12];
    assign rs1_s    = ir_q[19:15];
    assign rs2_s    = ir_q[24:20];

    // Immediate extraction for the format implied by the opcode.
    always_comb begin
        case (opcode_s)
            OP_STORE: imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BR:    imm_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OP_JAL:   imm_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            OP_LUI:   imm_s = {ir_q[31:12], 12'h000};
            default:  imm_s = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
    end

    // Shared ALU operand steering: PC+4 in FETCH, A+imm for addresses, OLDPC+imm for jump targets.
    always_comb begin
        alu_a_s  = pc_q;
        alu_b_s  = 32'd4;
        alu_op_s = ALU_ADD;
        case (state_q)
            S_MEMADR: begin
                alu_a_s = a_q;
                alu_b_s = imm_q;
            end
            S_EXEC: begin
                alu_a_s  = a_q;
                alu_b_s  = (opcode_s == OP_REG) ? b_q : imm_q;
                alu_op_s = alu_sel_f(funct3_s, ir_q[30], opcode_s == OP_REG);
            end
            S_BRANCH, S_JAL: begin
                alu_a_s = oldpc_q;
                alu_b_s = imm_q;
            end
            default: begin
                alu_a_s = pc_q;
                alu_b_s = 32'd4;
            end
        endcase
        alu_y_s = alu_f(alu_op_s, alu_a_s, alu_b_s);
    end

    // Next-state, datapath register updates and memory port decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        oldpc_d    = oldpc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        aluout_d   = aluout_q;
        mdr_d      = mdr_q;
        rf_d       = rf_q;
        cpu_out_d  = cpu_out_q;
        rf_we_s    = 1'b0;
        rf_wdata_s = 32'd0;
        take_s     = 1'b0;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = aluout_q[MEM_AW-1:0];
        case (state_q)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                mem_addr_s = pc_q[MEM_AW-1:0];
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    oldpc_d = pc_q;
                    pc_d    = alu_y_s;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d   = (rs1_s == 5'd0) ? 32'd0 : rf_q[rs1_s];
                b_d   = (rs2_s == 5'd0) ? 32'd0 : rf_q[rs2_s];
                imm_d = imm_s;
                case (opcode_s)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG, OP_IMM:    state_d = S_EXEC;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                aluout_d = alu_y_s;
                if (alu_y_s[1:0] != 2'b00) begin
                    state_d = S_HALT;
                end else if (opcode_s == OP_LOAD) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMWB: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = mdr_q;
                state_d    = S_FETCH;
            end
            S_EXEC: begin
                aluout_d = alu_y_s;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = aluout_q;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                case (funct3_s)
                    3'b000:  take_s = (a_q == b_q);
                    3'b001:  take_s = (a_q != b_q);
                    3'b100:  take_s = ($signed(a_q) < $signed(b_q));
                    3'b101:  take_s = ($signed(a_q) >= $signed(b_q));
                    default: state_d = S_HALT;
                endcase
                if (take_s) begin
                    pc_d = alu_y_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_JAL: begin
                // PC already holds OLDPC+4 from the fetch, which is the link value.
                rf_we_s    = 1'b1;
                rf_wdata_s = pc_q;
                pc_d       = alu_y_s;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                rf_we_s    = 1'b1;
                rf_wdata_s = imm_q;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        if (rf_we_s && (rd_s != 5'd0)) begin
            rf_d[rd_s] = rf_wdata_s;
            cpu_out_d  = rf_wdata_s[OUT_W-1:0];
        end else begin
            cpu_out_d = cpu_out_q;
        end
        halted_d = (state_d == S_HALT);
    end

    // Architectural and FSM state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            oldpc_q   <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            imm_q     <= 32'd0;
            aluout_q  <= 32'd0;
            mdr_q     <= 32'd0;
            rf_q      <= '{default: 32'd0};
            cpu_out_q <= {OUT_W{1'b0}};
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            oldpc_q   <= oldpc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            rf_q      <= rf_d;
            cpu_out_q <= cpu_out_d;
            halted_q  <= halted_d;
        end
    end

    // Reset gates the request so an in-flight access is dropped immediately.
    assign mem_req   = mem_req_s & ~reset;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = b_q;
    assign cpu_out   = cpu_out_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Self-checking bench: an instruction-level model predicts every bus access and cpu_out value,
// run against directed programs and random programs with random memory wait states.
module tb_riscv_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [7:0]  cpu_out;
    logic        halted;

    always #5 clk = ~clk;

    riscv_multicycle #(.MEM_AW(10), .RESET_PC(32'h0000_0000), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .cpu_out(cpu_out), .halted(halted)
    );

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  cout;
        logic        fetch;
    } acc_t;

    logic [31:0] tb_mem [0:255];
    acc_t        exp_q [$];
    int          n_vec = 0, n_err = 0;
    int          rdy_mode, rdy_delay, wait_cnt, hold_cnt, pc_w;
    bit          trace_on;
    logic [9:0]  last_fetch;
    logic [7:0]  cpu_at [0:63];

    assign mem_rdata = tb_mem[mem_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic emit(input logic [31:0] w);
        tb_mem[pc_w] = w;
        pc_w++;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) tb_mem[i] = $urandom;
        pc_w = 0;
    endtask

    function automatic logic [31:0] iss_alu(input logic [2:0] f3, input logic alt, input logic is_r,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return (is_r && alt) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return $signed(a) >>> b[4:0];
                return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Instruction-set model: executes the program from tb_mem and queues the expected bus accesses.
    task automatic iss_run();
        logic [31:0] r [32];
        logic [31:0] im [0:255];
        logic [31:0] pc, ir, npc, v, ea, r1, r2, immi, imms, immb, immj;
        logic [7:0]  cout;
        bit          stop, wr, take;
        for (int i = 0; i < 256; i++) im[i] = tb_mem[i];
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc = 32'd0; cout = 8'd0; stop = 0;
        exp_q.delete();
        for (int step = 0; step < 4000 && !stop; step++) begin
            ir = im[pc[9:2]];
            exp_q.push_back('{1'b0, pc[9:0], 32'd0, cout, 1'b1});
            r1   = r[ir[19:15]];
            r2   = r[ir[24:20]];
            immi = {{20{ir[31]}}, ir[31:20]};
            imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            immj = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            npc = pc + 32'd4; wr = 0; v = 32'd0; take = 0;
            case (ir[6:0])
                7'b0110011: begin v = iss_alu(ir[14:12], ir[30], 1'b1, r1, r2); wr = 1; end
                7'b0010011: begin v = iss_alu(ir[14:12], ir[30], 1'b0, r1, immi); wr = 1; end
                7'b0110111: begin v = {ir[31:12], 12'h000}; wr = 1; end
                7'b1101111: begin v = pc + 32'd4; npc = pc + immj; wr = 1; end
                7'b1100011: begin
                    case (ir[14:12])
                        3'b000: take = (r1 == r2);
                        3'b001: take = (r1 != r2);
                        3'b100: take = ($signed(r1) < $signed(r2));
                        3'b101: take = ($signed(r1) >= $signed(r2));
                        default: stop = 1;
                    endcase
                    if (take) npc = pc + immb;
                end
                7'b0000011: begin
                    ea = r1 + immi;
                    if (ea[1:0] != 2'b00) stop = 1;
                    else begin
                        exp_q.push_back('{1'b0, ea[9:0], 32'd0, 8'd0, 1'b0});
                        v = im[ea[9:2]]; wr = 1;
                    end
                end
                7'b0100011: begin
                    ea = r1 + imms;
                    if (ea[1:0] != 2'b00) stop = 1;
                    else begin
                        exp_q.push_back('{1'b1, ea[9:0], r2, 8'd0, 1'b0});
                        im[ea[9:2]] = r2;
                    end
                end
                default: stop = 1;
            endcase
            if (wr && !stop && ir[11:7] != 5'd0) begin
                r[ir[11:7]] = v;
                cout = v[7:0];
            end
            pc = npc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; wait_cnt = 0;
    endtask

    // One memory cycle: choose mem_ready, then complete and check any handshake before the edge.
    task automatic service();
        acc_t e;
        if (rdy_mode == 0)      mem_ready = 1'b1;
        else if (rdy_mode == 1) mem_ready = 1'($urandom_range(0, 1));
        else                    mem_ready = (wait_cnt >= rdy_delay);
        #1;
        if (mem_req) begin
            if (mem_ready) wait_cnt = 0; else wait_cnt++;
            if (mem_we && mem_addr == 10'h040 && mem_wdata == 32'd2) hold_cnt++;
        end
        if (mem_req && mem_ready) begin
            if (mem_we) tb_mem[mem_addr[9:2]] = mem_wdata;
            else        last_fetch = mem_addr;
            if (trace_on) begin
                if (exp_q.size() == 0) begin
                    check("extra_access", {22'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_we", {31'd0, mem_we}, {31'd0, e.we});
                    check("acc_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                    if (e.we) check("acc_wdata", mem_wdata, e.wdata);
                    if (e.fetch) check("cpu_out", {24'd0, cpu_out}, {24'd0, e.cout});
                end
            end
        end
    endtask

    task automatic run_prog(input int max_cyc);
        int         k, bad;
        logic [7:0] c0;
        iss_run();
        do_reset();
        trace_on = 1; hold_cnt = 0;
        for (int i = 0; i < 64; i++) cpu_at[i] = 8'd0;
        service();
        k = 0;
        while (!halted && k < max_cyc) begin
            @(negedge clk);
            k++;
            if (k < 64) cpu_at[k] = cpu_out;
            if (!halted) service();
        end
        trace_on = 0;
        check("halt_reached", {31'd0, halted}, 32'd1);
        check("trace_left", exp_q.size(), 32'd0);
        bad = 0; c0 = cpu_out;
        repeat (20) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_req || !halted || cpu_out != c0) bad++;
        end
        check("halt_hold", bad, 32'd0);
    endtask

    task automatic gen_random();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          n;
        clear_prog();
        n = $urandom_range(20, 40);
        for (int i = 0; i < n; i++) begin
            rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31)); f3 = 3'($urandom_range(0, 7));
            sh = 5'($urandom_range(0, 31)); imm = 12'($urandom);
            case ($urandom_range(0, 7))
                0, 1: emit(enc_r((((f3 == 3'd0) || (f3 == 3'd5)) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                 rs2, rs1, f3, rd));
                2, 3: begin
                    if (f3 == 3'd1) imm = {7'h00, sh};
                    if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, sh};
                    emit(enc_i(imm, rs1, f3, rd, 7'b0010011));
                end
                4: emit(enc_u(20'($urandom), rd));
                5: begin
                    imm = 12'h200 + 12'(4 * $urandom_range(0, 63));
                    if ($urandom_range(0, 1) == 1) emit(enc_s(imm, rs2, 5'd0));
                    else emit(enc_i(imm, 5'd0, 3'b010, rd, 7'b0000011));
                end
                6: begin
                    case ($urandom_range(0, 3))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                    emit(enc_b(13'd8, rs2, rs1, f3));
                end
                default: emit(enc_j(21'd8, rd));
            endcase
        end
        for (int i = 1; i < 32; i++) emit(enc_s(12'h300 + 12'(4 * i), 5'(i), 5'd0));
        emit(32'h0000_0000);
    endtask

    initial begin
        int seen;
        reset = 1'b1; mem_ready = 1'b0; trace_on = 0; rdy_mode = 0; rdy_delay = 0;
        wait_cnt = 0; hold_cnt = 0; last_fetch = 10'h3FF;
        #12;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_cpu_out", {24'd0, cpu_out}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // ALU sequence with zero-wait memory, cycle-exact commits
        clear_prog();
        emit(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
        emit(enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011));
        emit(enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3));
        emit(32'h0000_0000);
        rdy_mode = 0;
        run_prog(500);
        check("cyc3_out", {24'd0, cpu_at[3]}, 32'h00);
        check("cyc4_out", {24'd0, cpu_at[4]}, 32'h05);
        check("cyc8_out", {24'd0, cpu_at[8]}, 32'h07);
        check("cyc12_out", {24'd0, cpu_at[12]}, 32'h02);

        // Store then load with three wait cycles per access
        clear_prog();
        emit(enc_i(12'd2, 5'd0, 3'b000, 5'd3, 7'b0010011));
        emit(enc_s(12'h040, 5'd3, 5'd0));
        emit(enc_i(12'h040, 5'd0, 3'b010, 5'd4, 7'b0000011));
        emit(enc_s(12'h044, 5'd4, 5'd0));
        emit(32'h0000_0000);
        tb_mem[16] = 32'd0; tb_mem[17] = 32'd0;
        rdy_mode = 2; rdy_delay = 3;
        run_prog(500);
        check("sw_hold_cycles", hold_cnt, 32'd4);
        check("lw_result", tb_mem[17], 32'd2);

        // Countdown loop with a backward bne
        clear_prog();
        emit(enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011));
        emit(enc_i(12'hFFF, 5'd1, 3'b000, 5'd1, 7'b0010011));
        emit(enc_b(13'h1FFC, 5'd0, 5'd1, 3'b001));
        emit(32'h0000_0000);
        rdy_mode = 1;
        run_prog(500);
        check("loop_exit_pc", {22'd0, last_fetch}, 32'h0C);
        check("loop_out", {24'd0, cpu_out}, 32'h00);

        // jal link/target, lui, sra
        clear_prog();
        repeat (4) emit(enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011));
        emit(enc_j(21'd8, 5'd5));
        emit(32'h0000_0000);
        emit(enc_u(20'h12345, 5'd6));
        emit(enc_u(20'h80000, 5'd7));
        emit(enc_i(12'd4, 5'd0, 3'b000, 5'd8, 7'b0010011));
        emit(enc_r(7'h20, 5'd8, 5'd7, 3'b101, 5'd9));
        emit(enc_s(12'h100, 5'd5, 5'd0));
        emit(enc_s(12'h104, 5'd6, 5'd0));
        emit(enc_s(12'h108, 5'd9, 5'd0));
        emit(32'h0000_0000);
        run_prog(500);
        check("jal_link", tb_mem[64], 32'h0000_0014);
        check("lui_val", tb_mem[65], 32'h1234_5000);
        check("sra_val", tb_mem[66], 32'hF800_0000);

        // Misaligned load and illegal opcode both halt
        clear_prog();
        emit(enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011));
        emit(enc_i(12'h040, 5'd1, 3'b010, 5'd2, 7'b0000011));
        run_prog(500);
        check("misalign_out", {24'd0, cpu_out}, 32'h01);
        check("misalign_pc", {22'd0, last_fetch}, 32'h04);
        clear_prog();
        emit(32'h0000_0000);
        run_prog(500);
        check("illegal_pc", {22'd0, last_fetch}, 32'h00);
        check("illegal_out", {24'd0, cpu_out}, 32'h00);

        // Reset during a stalled store
        clear_prog();
        emit(enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011));
        emit(enc_s(12'h040, 5'd1, 5'd0));
        emit(32'h0000_0000);
        tb_mem[16] = 32'hDEAD_BEEF;
        rdy_mode = 2; rdy_delay = 10;
        do_reset();
        service();
        seen = 0;
        for (int c = 0; c < 200 && seen < 2; c++) begin
            @(negedge clk);
            service();
            if (mem_req && mem_we) seen++;
        end
        check("memwr_seen", seen, 32'd2);
        reset = 1'b1;
        #1;
        check("rst_req_drop", {31'd0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_no_write", tb_mem[16], 32'hDEAD_BEEF);
        check("rst_out_clear", {24'd0, cpu_out}, 32'h00);
        reset = 1'b0; rdy_mode = 0;
        #1;
        check("restart_req", {31'd0, mem_req}, 32'd1);
        check("restart_we", {31'd0, mem_we}, 32'd0);
        check("restart_addr", {22'd0, mem_addr}, 32'h000);

        // Random programs against the model, random wait states
        rdy_mode = 1;
        for (int p = 0; p < 8; p++) begin
            gen_random();
            run_prog(4000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
